// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, address-LSB helper and byte-strobe merge.
package axil_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Number of byte-offset bits below the word index for a bus of width dw.
  function automatic int unsigned addrlsb(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

  // Sized for the widest supported bus; narrower callers zero-extend and truncate.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_data,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_data;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_regfile.sv
// Register array with one byte-enabled write port, one async read port and a flat view.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LgNRegs   = 3
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                we_i,
  input  logic [LgNRegs-1:0]                  widx_i,
  input  logic [DataWidth-1:0]                wdata_i,
  input  logic [DataWidth/8-1:0]              wstrb_i,
  input  logic [LgNRegs-1:0]                  ridx_i,
  output logic [DataWidth-1:0]                rdata_o,
  output logic [(2**LgNRegs)*DataWidth-1:0]   regs_o
);

  localparam int unsigned NRegs = 2 ** LgNRegs;

  logic [DataWidth-1:0] regs_q [NRegs];
  logic [DataWidth-1:0] merged;

  always_comb begin
    merged = DataWidth'(strb_merge(64'(regs_q[widx_i]), 64'(wdata_i), 8'(wstrb_i)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NRegs; k++) regs_q[k] <= '0;
    end else if (we_i) begin
      regs_q[widx_i] <= merged;
    end
  end

  always_comb begin
    rdata_o = regs_q[ridx_i];
    regs_o  = '0;
    for (int k = 0; k < NRegs; k++) regs_o[k*DataWidth +: DataWidth] = regs_q[k];
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register responder with flat register output.
// Define AXIL_REG_SLAVE_ADDR_CHECK_EN to reject out-of-range addresses with SLVERR.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 6,
  parameter int unsigned LGNREGS          = 3
) (
  input  logic                                       i_clk,
  input  logic                                       i_axi_reset_n,
  input  logic                                       i_axi_awvalid,
  output logic                                       o_axi_awready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]                i_axi_awaddr,
  input  logic [2:0]                                 i_axi_awprot,
  input  logic                                       i_axi_wvalid,
  output logic                                       o_axi_wready,
  input  logic [C_AXI_DATA_WIDTH-1:0]                i_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]              i_axi_wstrb,
  output logic                                       o_axi_bvalid,
  input  logic                                       i_axi_bready,
  output logic [1:0]                                 o_axi_bresp,
  input  logic                                       i_axi_arvalid,
  output logic                                       o_axi_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]                i_axi_araddr,
  input  logic [2:0]                                 i_axi_arprot,
  output logic                                       o_axi_rvalid,
  input  logic                                       i_axi_rready,
  output logic [C_AXI_DATA_WIDTH-1:0]                o_axi_rdata,
  output logic [1:0]                                 o_axi_rresp,
  output logic [(2**LGNREGS)*C_AXI_DATA_WIDTH-1:0]   o_regs
);

  localparam int unsigned DW      = C_AXI_DATA_WIDTH;
  localparam int unsigned AW      = C_AXI_ADDR_WIDTH;
  localparam int unsigned ADDRLSB = addrlsb(DW);

  logic          aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d, reg_rdata;
  logic          aw_hs, w_hs, ar_hs, commit, waddr_ok, raddr_ok;
  logic [LGNREGS-1:0] widx, ridx;

  assign o_axi_awready = i_axi_reset_n && !aw_full_q;
  assign o_axi_wready  = i_axi_reset_n && !w_full_q;
  assign o_axi_arready = i_axi_reset_n && (!rvalid_q || i_axi_rready);

  assign aw_hs  = i_axi_awvalid && o_axi_awready;
  assign w_hs   = i_axi_wvalid && o_axi_wready;
  assign ar_hs  = i_axi_arvalid && o_axi_arready;
  assign commit = aw_full_q && w_full_q && (!bvalid_q || i_axi_bready);

  assign widx = awaddr_q[ADDRLSB +: LGNREGS];
  assign ridx = i_axi_araddr[ADDRLSB +: LGNREGS];

  always_comb begin
`ifdef AXIL_REG_SLAVE_ADDR_CHECK_EN
    waddr_ok = (awaddr_q >> (ADDRLSB + LGNREGS)) == '0;
    raddr_ok = (i_axi_araddr >> (ADDRLSB + LGNREGS)) == '0;
`else
    waddr_ok = 1'b1;
    raddr_ok = 1'b1;
`endif
  end

  // Byte offsets, prot and (when unchecked) upper address bits are don't-care.
  logic unused_sig;
  assign unused_sig = ^{i_axi_awprot, i_axi_arprot, awaddr_q, i_axi_araddr};

  always_comb begin
    aw_full_d = aw_full_q;
    awaddr_d  = awaddr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    // Handshake and commit are mutually exclusive: each needs the opposite full state.
    if (aw_hs) begin
      aw_full_d = 1'b1;
      awaddr_d  = i_axi_awaddr;
    end else if (commit) begin
      aw_full_d = 1'b0;
    end

    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = i_axi_wdata;
      wstrb_d  = i_axi_wstrb;
    end else if (commit) begin
      w_full_d = 1'b0;
    end

    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = waddr_ok ? OKAY : SLVERR;
    end else if (i_axi_bready) begin
      bvalid_d = 1'b0;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = raddr_ok ? reg_rdata : '0;
      rresp_d  = raddr_ok ? OKAY : SLVERR;
    end else if (i_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      aw_full_q <= 1'b0;
      awaddr_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      awaddr_q  <= awaddr_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign o_axi_bvalid = bvalid_q;
  assign o_axi_bresp  = bresp_q;
  assign o_axi_rvalid = rvalid_q;
  assign o_axi_rdata  = rdata_q;
  assign o_axi_rresp  = rresp_q;

  axil_regfile #(
    .DataWidth (DW),
    .LgNRegs   (LGNREGS)
  ) u_regfile (
    .clk_i   (i_clk),
    .rst_ni  (i_axi_reset_n),
    .we_i    (commit && waddr_ok),
    .widx_i  (widx),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .ridx_i  (ridx),
    .rdata_o (reg_rdata),
    .regs_o  (o_regs)
  );

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: vector table plus cycle-exact handshake sequences.
module tb_axil_reg_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;
  localparam int unsigned LGN = 3;
  localparam int unsigned NREGS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NREGS*DW-1:0] regs;

  axil_reg_slave #(
    .C_AXI_DATA_WIDTH (DW),
    .C_AXI_ADDR_WIDTH (AW),
    .LGNREGS          (LGN)
  ) dut (
    .i_clk         (clk),
    .i_axi_reset_n (rst_n),
    .i_axi_awvalid (awvalid),
    .o_axi_awready (awready),
    .i_axi_awaddr  (awaddr),
    .i_axi_awprot  (awprot),
    .i_axi_wvalid  (wvalid),
    .o_axi_wready  (wready),
    .i_axi_wdata   (wdata),
    .i_axi_wstrb   (wstrb),
    .o_axi_bvalid  (bvalid),
    .i_axi_bready  (bready),
    .o_axi_bresp   (bresp),
    .i_axi_arvalid (arvalid),
    .o_axi_arready (arready),
    .i_axi_araddr  (araddr),
    .i_axi_arprot  (arprot),
    .o_axi_rvalid  (rvalid),
    .i_axi_rready  (rready),
    .o_axi_rdata   (rdata),
    .o_axi_rresp   (rresp),
    .o_regs        (regs)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_regs [NREGS];

  typedef struct {
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    int              idx;
    logic [DW-1:0]   exp;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [DW-1:0] reg_at(input int k);
    return regs[k*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_regs(input string tag);
    for (int k = 0; k < NREGS; k++) check($sformatf("%s_reg%0d", tag, k), reg_at(k), exp_regs[k]);
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [DW/8-1:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, a_hs, d_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      a_hs = awvalid && awready;
      d_hs = wvalid && wready;
      tick();
      if (a_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (d_hs) begin wvalid = 1'b0; w_done = 1; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      timeout("write_handshake");
      awvalid = 1'b0; wvalid = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!bvalid) timeout("write_resp");
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    bit done, hs;
    int n;
    done = 0; n = 0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      hs = arready;
      tick();
      if (hs) begin arvalid = 1'b0; done = 1; end
      n++;
    end
    if (!done) begin
      timeout("read_handshake");
      arvalid = 1'b0;
    end
    @(negedge clk);
    check("read_latency", rvalid, 1);
    data = rdata;
    resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp;
    logic [DW-1:0] data;

    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
    for (int k = 0; k < NREGS; k++) exp_regs[k] = '0;

    vecs[0] = '{6'h00, 32'hA5A5A5A5, 4'hF, 0, 32'hA5A5A5A5};
    vecs[1] = '{6'h04, 32'hAABBCCDD, 4'hC, 1, 32'hAABB3344};
    vecs[2] = '{6'h0C, 32'hFFFFFFFF, 4'h4, 3, 32'h00FF0000};
    vecs[3] = '{6'h0C, 32'h12345678, 4'h8, 3, 32'h12FF0000};
    vecs[4] = '{6'h1F, 32'hCAFEF00D, 4'hF, 7, 32'hCAFEF00D};
    vecs[5] = '{6'h00, 32'h00000000, 4'h0, 0, 32'hA5A5A5A5};
    vecs[6] = '{6'h18, 32'h0000BEEF, 4'h1, 6, 32'h000000EF};

    // Reset state
    #3;
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_regs_zero", (regs == '0), 1);
    #9 rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_awready", awready, 1);
    check("post_rst_wready", wready, 1);
    check("post_rst_arready", arready, 1);
    tick();

    // AW+W same cycle: bvalid two cycles later
    awaddr = 6'h08; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    check("t1_awready", awready, 1);
    check("t1_wready", wready, 1);
    tick();
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("t1_bvalid_c1", bvalid, 0);
    tick();
    @(negedge clk);
    check("t1_bvalid_c2", bvalid, 1);
    check("t1_bresp", bresp, 0);
    check("t1_reg2", reg_at(2), 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("t1_bvalid_drop", bvalid, 0);
    tick();
    bready = 0;
    exp_regs[2] = 32'hDEADBEEF;
    axi_read(6'h08, data, resp);
    check("t1_rdata", data, 32'hDEADBEEF);
    check("t1_rresp", resp, 0);

    // W three cycles ahead of AW
    wdata = 32'h11223344; wstrb = 4'h3; wvalid = 1; bready = 1;
    @(negedge clk);
    check("t2_wready_c0", wready, 1);
    tick();
    wvalid = 0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check($sformatf("t2_awready_c%0d", c), awready, 1);
      check($sformatf("t2_wready_c%0d", c), wready, 0);
      check($sformatf("t2_bvalid_c%0d", c), bvalid, 0);
      tick();
    end
    awaddr = 6'h04; awvalid = 1;
    @(negedge clk);
    check("t2_awready_c3", awready, 1);
    check("t2_wready_c3", wready, 0);
    tick();
    awvalid = 0;
    @(negedge clk);
    check("t2_bvalid_c4", bvalid, 0);
    check("t2_wready_c4", wready, 0);
    tick();
    @(negedge clk);
    check("t2_bvalid_c5", bvalid, 1);
    check("t2_bresp", bresp, 0);
    check("t2_reg1", reg_at(1), 32'h00003344);
    check("t2_wready_c5", wready, 1);
    tick();
    bready = 0;
    exp_regs[1] = 32'h00003344;

    // Back-to-back ARs under rready backpressure
    araddr = 6'h08; arvalid = 1; rready = 0;
    @(negedge clk);
    check("t3_arready_c0", arready, 1);
    tick();
    araddr = 6'h04;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("t3_arready_c%0d", c), arready, 0);
      check($sformatf("t3_rvalid_c%0d", c), rvalid, 1);
      check($sformatf("t3_rdata_c%0d", c), rdata, 32'hDEADBEEF);
      tick();
    end
    rready = 1;
    @(negedge clk);
    check("t3_arready_c5", arready, 1);
    check("t3_rdata_c5", rdata, 32'hDEADBEEF);
    tick();
    arvalid = 0;
    @(negedge clk);
    check("t3_rvalid_c6", rvalid, 1);
    check("t3_rdata_c6", rdata, 32'h00003344);
    tick();
    @(negedge clk);
    check("t3_rvalid_c7", rvalid, 0);
    tick();
    rready = 0;

    // Vector table: strobe merges, ignored byte offsets, zero strobe
    for (int i = 0; i < 7; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
      check($sformatf("vec%0d_bresp", i), resp, 0);
      exp_regs[vecs[i].idx] = vecs[i].exp;
      check_all_regs($sformatf("vec%0d", i));
      axi_read(vecs[i].addr, data, resp);
      check($sformatf("vec%0d_rdata", i), data, vecs[i].exp);
      check($sformatf("vec%0d_rresp", i), resp, 0);
    end

    // Second write pair held off by a stalled B channel
    awaddr = 6'h10; wdata = 32'h00000055; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    check("t4_hs0", awready && wready, 1);
    tick();
    awaddr = 6'h14; wdata = 32'h00000066;
    @(negedge clk);
    check("t4_awready_c1", awready, 0);
    tick();
    @(negedge clk);
    check("t4_bvalid_c2", bvalid, 1);
    check("t4_awready_c2", awready, 1);
    check("t4_wready_c2", wready, 1);
    tick();
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    check("t4_awready_c3", awready, 0);
    check("t4_bvalid_c3", bvalid, 1);
    check("t4_reg4", reg_at(4), 32'h00000055);
    check("t4_reg5_c3", reg_at(5), 0);
    tick();
    @(negedge clk);
    check("t4_bvalid_c4", bvalid, 1);
    check("t4_reg5_c4", reg_at(5), 0);
    tick();
    bready = 1;
    @(negedge clk);
    check("t4_bvalid_c5", bvalid, 1);
    tick();
    @(negedge clk);
    check("t4_bvalid_c6", bvalid, 1);
    check("t4_reg5_c6", reg_at(5), 32'h00000066);
    check("t4_awready_c6", awready, 1);
    tick();
    bready = 0;
    @(negedge clk);
    check("t4_bvalid_c7", bvalid, 0);
    tick();
    exp_regs[4] = 32'h00000055;
    exp_regs[5] = 32'h00000066;

    // Out-of-range address
    axi_write(6'h20, 32'h77777777, 4'hF, resp);
`ifdef AXIL_REG_SLAVE_ADDR_CHECK_EN
    check("t5_bresp", resp, 2'b10);
    check_all_regs("t5");
    axi_read(6'h20, data, resp);
    check("t5_rdata", data, 0);
    check("t5_rresp", resp, 2'b10);
`else
    check("t5_bresp", resp, 2'b00);
    exp_regs[0] = 32'h77777777;
    check_all_regs("t5");
    axi_read(6'h20, data, resp);
    check("t5_rdata", data, 32'h77777777);
    check("t5_rresp", resp, 2'b00);
`endif

    // Reset with a latched AW and a pending R
    awaddr = 6'h0C; awvalid = 1; wvalid = 0;
    araddr = 6'h00; arvalid = 1; rready = 0;
    tick();
    awvalid = 0; arvalid = 0;
    @(negedge clk);
    check("t6_pre_awready", awready, 0);
    check("t6_pre_rvalid", rvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_awready", awready, 0);
    check("t6_wready", wready, 0);
    check("t6_arready", arready, 0);
    check("t6_bvalid", bvalid, 0);
    check("t6_rvalid", rvalid, 0);
    check("t6_rdata", rdata, 0);
    check("t6_regs_zero", (regs == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("t6_post_awready", awready, 1);
    check("t6_post_wready", wready, 1);
    check("t6_post_arready", arready, 1);
    check("t6_post_bvalid", bvalid, 0);
    tick();
    for (int k = 0; k < NREGS; k++) exp_regs[k] = '0;
    axi_write(6'h0C, 32'h0BADF00D, 4'hF, resp);
    check("t6_bresp", resp, 0);
    exp_regs[3] = 32'h0BADF00D;
    check_all_regs("t6");
    axi_read(6'h0C, data, resp);
    check("t6_read", data, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
